popcount_scheduler: RTL and testbench

Shares one fixed-latency, path-balanced 32-bit population-count pipeline among `NUM_REQ` requesters. Each requester submits a packet of 32-bit words, and the block returns one result per packet: the total number of set bits across the packet. It sits in front of the popcount datapath and handles arbitration, packet locking, ID tracking through the pipeline, accumulation and result buffering with credit-based backpressure.

---
 rtl/popcount_sched_pkg.sv | 29 ++
 rtl/popcount32_pipe.sv | 54 +++++
 rtl/popcount_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_popcount_scheduler.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/popcount_sched_pkg.sv
// Shared types and helpers for the popcount scheduler.
// Result entries are sized for the widest legal configuration.
package popcount_sched_pkg;

    localparam int WORD_W    = 32;
    localparam int CNT_W     = 6;
    localparam int ID_MAX_W  = 3;
    localparam int ACC_MAX_W = 32;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    typedef struct packed {
        logic [ID_MAX_W-1:0]  id;
        logic [ACC_MAX_W-1:0] count;
    } result_t;

    function automatic logic [CNT_W-1:0] popcount32(input logic [WORD_W-1:0] w);
        logic [CNT_W-1:0] n;
        n = '0;
        for (int i = 0; i < WORD_W; i++) begin
            n = n + CNT_W'(w[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/popcount32_pipe.sv
// Fixed-latency 32-bit popcount with a {valid, last, id} sideband
// delayed alongside the count.
module popcount32_pipe
    import popcount_sched_pkg::*;
#(
    parameter int LATENCY = 9,
    parameter int ID_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              in_last,
    input  logic [ID_W-1:0]   in_id,
    input  logic [WORD_W-1:0] in_data,
    output logic              out_valid,
    output logic              out_last,
    output logic [ID_W-1:0]   out_id,
    output logic [CNT_W-1:0]  out_cnt
);

    logic [LATENCY-1:0] vld;
    logic [LATENCY-1:0] lst;
    logic [ID_W-1:0]    ids [LATENCY];
    logic [CNT_W-1:0]   cnt [LATENCY];

    // Only the valid bits need reset; payload follows valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld <= '0;
        end else begin
            vld[0] <= in_valid;
            for (int s = 1; s < LATENCY; s++) begin
                vld[s] <= vld[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        lst[0] <= in_last;
        ids[0] <= in_id;
        cnt[0] <= popcount32(in_data);
        for (int s = 1; s < LATENCY; s++) begin
            lst[s] <= lst[s-1];
            ids[s] <= ids[s-1];
            cnt[s] <= cnt[s-1];
        end
    end

    assign out_valid = vld[LATENCY-1];
    assign out_last  = lst[LATENCY-1];
    assign out_id    = ids[LATENCY-1];
    assign out_cnt   = cnt[LATENCY-1];

endmodule

// File: rtl/popcount_scheduler.sv
// Arbitrates packets from several requesters onto one popcount pipeline
// and returns a saturated bit-count per packet through a result FIFO.
module popcount_scheduler
    import popcount_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int LATENCY   = 9,
    parameter int ACC_W     = 16,
    parameter int RES_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*WORD_W-1:0]  req_data,
    input  logic [NUM_REQ-1:0]         req_last,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic                       res_valid,
    input  logic                       res_ready,
    output logic [$clog2(NUM_REQ)-1:0] res_id,
    output logic [ACC_W-1:0]           res_count
);

    localparam int ID_W   = $clog2(NUM_REQ);
    localparam int PTR_W  = $clog2(RES_DEPTH);
    localparam int PEND_W = PTR_W + 1;

    state_t          state;
    state_t          state_nxt;
    logic [ID_W-1:0] grant_id;
    logic [ID_W-1:0] grant_nxt;
    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] rr_nxt;
    logic [ID_W-1:0] sel;
    logic            sel_found;
    logic            take;
    logic            word_last;
    logic [WORD_W-1:0] word;

    logic [PEND_W-1:0] lif;
    logic [PEND_W-1:0] fifo_cnt;
    logic [PEND_W:0]   pending;
    logic              credit_ok;

    logic              out_valid;
    logic              out_last;
    logic [ID_W-1:0]   out_id;
    logic [CNT_W-1:0]  out_cnt;

    logic [ACC_W-1:0]  acc;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  acc_sat;

    result_t           mem [RES_DEPTH];
    result_t           head;
    result_t           push_res;
    logic [PTR_W:0]    wr_ptr;
    logic [PTR_W:0]    rd_ptr;
    logic              push;
    logic              pop;
    logic              head_unused;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (int'(id) == NUM_REQ - 1) ? '0 : id + 1'b1;
    endfunction

    // Pending results bound both in-flight last words and FIFO occupancy.
    assign pending   = (PEND_W+1)'(lif) + (PEND_W+1)'(fifo_cnt);
    assign credit_ok = pending < (PEND_W+1)'(RES_DEPTH);

    always_comb begin
        int idx;
        idx       = 0;
        sel       = grant_id;
        sel_found = 1'b0;
        if (state == LOCKED) begin
            sel_found = req_valid[grant_id];
        end else begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(rr_ptr) + k) % NUM_REQ;
                if (!sel_found && req_valid[idx]) begin
                    sel_found = 1'b1;
                    sel       = ID_W'(idx);
                end
            end
        end
    end

    assign word_last = req_last[sel];
    assign word      = req_data[int'(sel)*WORD_W +: WORD_W];
    assign take      = !rst && sel_found && (!word_last || credit_ok);

    always_comb begin
        req_ready = '0;
        if (take) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_id;
        rr_nxt    = rr_ptr;
        if (take) begin
            if (word_last) begin
                state_nxt = IDLE;
                rr_nxt    = next_id(sel);
            end else begin
                state_nxt = LOCKED;
                grant_nxt = sel;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            grant_id <= '0;
            rr_ptr   <= '0;
        end else begin
            state    <= state_nxt;
            grant_id <= grant_nxt;
            rr_ptr   <= rr_nxt;
        end
    end

    popcount32_pipe #(
        .LATENCY (LATENCY),
        .ID_W    (ID_W)
    ) u_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (take),
        .in_last   (word_last),
        .in_id     (sel),
        .in_data   (word),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_id    (out_id),
        .out_cnt   (out_cnt)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lif <= '0;
        end else begin
            lif <= lif + PEND_W'(take && word_last) - PEND_W'(push);
        end
    end

    assign sum     = {1'b0, acc} + (ACC_W+1)'(out_cnt);
    assign acc_sat = sum[ACC_W] ? '1 : sum[ACC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (out_valid) begin
            acc <= out_last ? '0 : acc_sat;
        end
    end

    assign push           = out_valid && out_last;
    assign pop            = res_valid && res_ready;
    assign fifo_cnt       = wr_ptr - rd_ptr;
    assign push_res.id    = ID_MAX_W'(out_id);
    assign push_res.count = ACC_MAX_W'(acc_sat);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_res;
        end
    end

    assign head        = mem[rd_ptr[PTR_W-1:0]];
    assign head_unused = ^{head.id, head.count};
    assign res_valid   = fifo_cnt != '0;
    assign res_id      = res_valid ? head.id[ID_W-1:0] : '0;
    assign res_count   = res_valid ? head.count[ACC_W-1:0] : '0;

endmodule

// File: tb/tb_popcount_scheduler.sv
// Directed checks for popcount_scheduler; a second instance with an
// 8-bit accumulator shares the stimulus to exercise saturation.
module tb_popcount_scheduler;

    localparam int N   = 4;
    localparam int LAT = 9;
    localparam int DEP = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*32-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    s_req_ready;
    logic            res_valid;
    logic            s_res_valid;
    logic            res_ready;
    logic [1:0]      res_id;
    logic [1:0]      s_res_id;
    logic [15:0]     res_count;
    logic [7:0]      s_res_count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int got_id[$];
    int got_cnt[$];
    int grant_log[$];
    int grant_cyc[$];

    popcount_scheduler #(
        .NUM_REQ(N), .LATENCY(LAT), .ACC_W(16), .RES_DEPTH(DEP)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_id(res_id), .res_count(res_count)
    );

    popcount_scheduler #(
        .NUM_REQ(N), .LATENCY(LAT), .ACC_W(8), .RES_DEPTH(DEP)
    ) dut_sat (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(s_req_ready),
        .res_valid(s_res_valid), .res_ready(res_ready),
        .res_id(s_res_id), .res_count(s_res_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (res_valid && res_ready) begin
            got_id.push_back(int'(res_id));
            got_cnt.push_back(int'(res_count));
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                grant_log.push_back(i);
                grant_cyc.push_back(cyc);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input int i, input logic [31:0] d, input logic l);
        req_valid[i]       = 1'b1;
        req_data[i*32 +: 32] = d;
        req_last[i]        = l;
    endtask

    task automatic do_reset();
        step();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        got_id.delete();
        got_cnt.delete();
        grant_log.delete();
        grant_cyc.delete();
    endtask

    task automatic wait_results(input string tag, input int n, input int budget);
        int k;
        k = 0;
        while (got_id.size() < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk(tag, 64'(got_id.size()), 64'(n));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    logic [31:0] bp_data [6];
    int t0;
    int k;
    int nacc;

    initial begin
        bp_data = '{32'h1, 32'h3, 32'h7, 32'hF, 32'h1F, 32'h3F};
        rst       = 1'b1;
        res_ready = 1'b1;
        idle_inputs();
        req_valid = '1;
        req_last  = '1;
        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_id", res_id, 0);
        chk("rst_res_count", res_count, 0);
        do_reset();

        // single word from requester 2
        step();
        set_word(2, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk);
        chk("single_ready", req_ready, 4'b0100);
        t0 = cyc;
        step();
        idle_inputs();
        k = 0;
        while (!res_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("single_latency", 64'(cyc - t0), 64'(LAT + 1));
        chk("single_id", res_id, 2);
        chk("single_count", res_count, 32);

        // round-robin with all requesters valid
        do_reset();
        step();
        for (int i = 0; i < N; i++) set_word(i, 32'h1, 1'b1);
        k = 0;
        while (grant_log.size() < 8 && k < 200) begin
            @(posedge clk);
            k++;
        end
        #1;
        idle_inputs();
        chk("rr_grants", 64'(grant_log.size()), 8);
        chk("rr_back_to_back", 64'(grant_cyc[3] - grant_cyc[0]), 3);
        for (int j = 0; j < 8; j++) chk($sformatf("rr_grant%0d", j), 64'(grant_log[j]), 64'(j % 4));
        wait_results("rr_nres", 8, 200);
        for (int j = 0; j < 8; j++) begin
            chk($sformatf("rr_id%0d", j), 64'(got_id[j]), 64'(j % 4));
            chk($sformatf("rr_cnt%0d", j), 64'(got_cnt[j]), 1);
        end

        // packet lock: requester 1 holds the pipeline over requester 0
        do_reset();
        step();
        set_word(1, 32'hF, 1'b0);
        @(negedge clk);
        chk("lock_w0", req_ready, 4'b0010);
        step();
        set_word(1, 32'hFF, 1'b0);
        set_word(0, 32'hF0, 1'b1);
        @(negedge clk);
        chk("lock_w1", req_ready, 4'b0010);
        step();
        set_word(1, 32'h0, 1'b1);
        @(negedge clk);
        chk("lock_w2", req_ready, 4'b0010);
        step();
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("lock_r0", req_ready, 4'b0001);
        step();
        idle_inputs();
        wait_results("lock_nres", 2, 60);
        chk("lock_id0", 64'(got_id[0]), 1);
        chk("lock_cnt0", 64'(got_cnt[0]), 12);
        chk("lock_id1", 64'(got_id[1]), 0);
        chk("lock_cnt1", 64'(got_cnt[1]), 4);

        // backpressure: result FIFO credit limits accepted last words
        do_reset();
        res_ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < 30; c++) begin
            step();
            idle_inputs();
            if (nacc < 6) set_word(0, bp_data[nacc], 1'b1);
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) nacc++;
        end
        chk("bp_accepted", 64'(nacc), 64'(DEP));
        chk("bp_stall", req_ready, 0);
        chk("bp_res_valid", res_valid, 1);
        chk("bp_head_held", res_count, 1);
        step();
        res_ready = 1'b1;
        for (int c = 0; c < 100 && nacc < 6; c++) begin
            idle_inputs();
            set_word(0, bp_data[nacc], 1'b1);
            @(negedge clk);
            if (req_valid[0] && req_ready[0]) nacc++;
            step();
        end
        idle_inputs();
        chk("bp_all_accepted", 64'(nacc), 6);
        wait_results("bp_nres", 6, 100);
        for (int j = 0; j < 6; j++) chk($sformatf("bp_cnt%0d", j), 64'(got_cnt[j]), 64'(j + 1));

        // saturation: 10 full words, 320 bits
        do_reset();
        nacc = 0;
        for (int w = 0; w < 10; w++) begin
            step();
            set_word(0, 32'hFFFF_FFFF, w == 9);
            @(negedge clk);
            if (req_ready[0]) nacc++;
        end
        step();
        idle_inputs();
        chk("sat_words", 64'(nacc), 10);
        k = 0;
        while (!s_res_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("sat_count8", s_res_count, 8'd255);
        chk("sat_id8", s_res_id, 0);
        wait_results("sat_nres", 1, 40);
        chk("sat_count16", 64'(got_cnt[0]), 320);

        // reset mid-packet discards the partial packet
        do_reset();
        step();
        set_word(2, 32'h1, 1'b1);
        step();
        idle_inputs();
        wait_results("mr_pre", 1, 40);
        got_id.delete();
        got_cnt.delete();
        step();
        set_word(3, 32'hFF, 1'b0);
        step();
        step();
        rst = 1'b1;
        idle_inputs();
        step();
        step();
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("mr_no_result", 64'(got_id.size()), 0);
        chk("mr_res_valid", res_valid, 0);
        step();
        set_word(0, 32'h7, 1'b1);
        set_word(3, 32'hFFFF, 1'b1);
        @(negedge clk);
        chk("mr_rr_restart", req_ready, 4'b0001);
        step();
        idle_inputs();
        wait_results("mr_nres", 1, 40);
        chk("mr_id", 64'(got_id[0]), 0);
        chk("mr_cnt", 64'(got_cnt[0]), 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
